// File: rtl/des_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// des_pkg : DES key-schedule tables, widths and state encoding.
// Revision 1.0
// ----------------------------------------------------------------------------
package des_pkg;

  localparam int KEY_W      = 64;
  localparam int CD_W       = 28;
  localparam int SUBKEY_W   = 48;
  localparam int NUM_ROUNDS = 16;

  // Entries are 1-based FIPS bit numbers of the source vector.
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Encrypt rotation per output position; decrypt reuses entries 1..15.
  localparam logic [1:0] SHIFT_SCHED [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic [CD_W-1:0] rotl28(input logic [CD_W-1:0] v, input logic [1:0] n);
    logic [CD_W-1:0] r;
    case (n)
      2'd1:    r = {v[CD_W-2:0], v[CD_W-1]};
      2'd2:    r = {v[CD_W-3:0], v[CD_W-1:CD_W-2]};
      default: r = v;
    endcase
    return r;
  endfunction

  function automatic logic [CD_W-1:0] rotr28(input logic [CD_W-1:0] v, input logic [1:0] n);
    logic [CD_W-1:0] r;
    case (n)
      2'd1:    r = {v[0], v[CD_W-1:1]};
      2'd2:    r = {v[1:0], v[CD_W-1:2]};
      default: r = v;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/des_pc2_perm.sv
`default_nettype none
// ----------------------------------------------------------------------------
// des_pc2_perm : combinational PC-2 selection of 48 subkey bits from C||D.
// Revision 1.0
// ----------------------------------------------------------------------------
module des_pc2_perm
  import des_pkg::*;
(
  input  logic [2*CD_W-1:0]   i_cd,
  output logic [SUBKEY_W-1:0] o_subkey
);

  // FIPS bit 1 sits at the MSB of both vectors.
  for (genvar j = 0; j < SUBKEY_W; j++) begin : g_bit
    assign o_subkey[SUBKEY_W-1-j] = i_cd[2*CD_W - PC2[j]];
  end

endmodule

`default_nettype wire

// File: rtl/des_key_schedule.sv
`default_nettype none
// ----------------------------------------------------------------------------
// des_key_schedule : on-the-fly DES subkey generator, encrypt or decrypt order.
// Revision 1.0
// ----------------------------------------------------------------------------
module des_key_schedule
  import des_pkg::*;
#(
  parameter int PARITY_CHECK = 0
) (
  input  logic                wClk,
  input  logic                wReset,
  input  logic                wKeyValid,
  output logic                wKeyReady,
  input  logic [KEY_W-1:0]    wKey,
  input  logic                wDecrypt,
  output logic [SUBKEY_W-1:0] wSubkey,
  output logic                wSubkeyValid,
  input  logic                wSubkeyReady,
  output logic [3:0]          wRound,
  output logic                wLastRound,
  output logic                wKeyErr
);

  state_t          r_state;
  state_t          w_state_next;
  logic            w_load;
  logic            w_step;
  logic            w_finish;

  logic [CD_W-1:0] r_c;
  logic [CD_W-1:0] r_d;
  logic [3:0]      r_round;
  logic            r_decrypt;
  logic            r_err;
  logic            r_subkey_valid;
  logic            r_key_ready;

  logic [2*CD_W-1:0]   w_cd0;
  logic [SUBKEY_W-1:0] w_pc2;
  logic                w_parity_err;
  logic [3:0]          w_next_round;
  logic [1:0]          w_shift;
  logic                w_unused_par;

  for (genvar j = 0; j < 2*CD_W; j++) begin : g_pc1
    assign w_cd0[2*CD_W-1-j] = wKey[KEY_W - PC1[j]];
  end

  if (PARITY_CHECK != 0) begin : g_parity_on
    logic [7:0] w_byte_bad;
    for (genvar b = 0; b < 8; b++) begin : g_byte
      assign w_byte_bad[b] = ~^wKey[8*b +: 8];
    end
    assign w_parity_err = |w_byte_bad;
  end else begin : g_parity_off
    assign w_parity_err = 1'b0;
  end

  // Parity bits never reach the subkeys.
  assign w_unused_par = ^{wKey[56], wKey[48], wKey[40], wKey[32],
                          wKey[24], wKey[16], wKey[8],  wKey[0]};

  assign w_next_round = r_round + 4'd1;
  assign w_shift      = SHIFT_SCHED[w_next_round];

  always_ff @(posedge wClk) begin
    if (wReset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (wKeyValid) begin
          w_load       = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (wSubkeyReady) begin
          if (r_round == 4'd15) begin
            w_finish     = 1'b1;
            w_state_next = ST_IDLE;
          end else begin
            w_step = 1'b1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge wClk) begin
    if (wReset) begin
      r_c            <= '0;
      r_d            <= '0;
      r_round        <= 4'd0;
      r_decrypt      <= 1'b0;
      r_err          <= 1'b0;
      r_subkey_valid <= 1'b0;
      r_key_ready    <= 1'b1;
    end else if (w_load) begin
      // Decrypt starts from C16/D16, which equal C0/D0.
      r_c            <= wDecrypt ? w_cd0[2*CD_W-1:CD_W] : rotl28(w_cd0[2*CD_W-1:CD_W], 2'd1);
      r_d            <= wDecrypt ? w_cd0[CD_W-1:0]      : rotl28(w_cd0[CD_W-1:0], 2'd1);
      r_round        <= 4'd0;
      r_decrypt      <= wDecrypt;
      r_err          <= w_parity_err;
      r_subkey_valid <= 1'b1;
      r_key_ready    <= 1'b0;
    end else if (w_step) begin
      r_c     <= r_decrypt ? rotr28(r_c, w_shift) : rotl28(r_c, w_shift);
      r_d     <= r_decrypt ? rotr28(r_d, w_shift) : rotl28(r_d, w_shift);
      r_round <= w_next_round;
    end else if (w_finish) begin
      r_round        <= 4'd0;
      r_err          <= 1'b0;
      r_subkey_valid <= 1'b0;
      r_key_ready    <= 1'b1;
    end
  end

  des_pc2_perm u_pc2 (
    .i_cd     ({r_c, r_d}),
    .o_subkey (w_pc2)
  );

  assign wSubkey      = r_subkey_valid ? w_pc2 : '0;
  assign wSubkeyValid = r_subkey_valid;
  assign wKeyReady    = r_key_ready;
  assign wRound       = r_round;
  assign wLastRound   = r_subkey_valid & (r_round == 4'd15);
  assign wKeyErr      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_des_key_schedule.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_des_key_schedule : randomized bench against a table-driven DES key model.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_des_key_schedule;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        key_valid;
  logic [63:0] key;
  logic        decrypt;
  logic        sk_ready;

  logic        key_ready_p, sk_valid_p, last_p, err_p;
  logic [47:0] sk_p;
  logic [3:0]  rnd_p;
  logic        key_ready_n, sk_valid_n, last_n, err_n;
  logic [47:0] sk_n;
  logic [3:0]  rnd_n;

  int n_checks = 0;
  int n_errors = 0;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int ENC_SHIFT [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  logic [47:0] ref_ks [16];
  logic [47:0] cap    [16];

  des_key_schedule #(.PARITY_CHECK(1)) u_dut_p (
    .wClk(clk), .wReset(rst), .wKeyValid(key_valid), .wKeyReady(key_ready_p),
    .wKey(key), .wDecrypt(decrypt), .wSubkey(sk_p), .wSubkeyValid(sk_valid_p),
    .wSubkeyReady(sk_ready), .wRound(rnd_p), .wLastRound(last_p), .wKeyErr(err_p)
  );

  des_key_schedule #(.PARITY_CHECK(0)) u_dut_n (
    .wClk(clk), .wReset(rst), .wKeyValid(key_valid), .wKeyReady(key_ready_n),
    .wKey(key), .wDecrypt(decrypt), .wSubkey(sk_n), .wSubkeyValid(sk_valid_n),
    .wSubkeyReady(sk_ready), .wRound(rnd_n), .wLastRound(last_n), .wKeyErr(err_n)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Cumulative-shift formulation: round r reads C0/D0 rotated left by the running sum.
  task automatic build_model(input logic [63:0] k);
    bit c [28];
    bit d [28];
    int s;
    int p;
    s = 0;
    for (int j = 0; j < 28; j++) begin
      c[j] = k[64 - PC1_T[j]];
      d[j] = k[64 - PC1_T[28 + j]];
    end
    for (int r = 0; r < 16; r++) begin
      s += ENC_SHIFT[r];
      for (int j = 0; j < 48; j++) begin
        p = PC2_T[j] - 1;
        ref_ks[r][47 - j] = (p < 28) ? c[(p + s) % 28] : d[(p - 28 + s) % 28];
      end
    end
  endtask

  function automatic bit parity_err(input logic [63:0] k);
    logic [7:0] bv;
    bit e;
    e = 1'b0;
    for (int b = 0; b < 8; b++) begin
      bv = k[8*b +: 8];
      if (($countones(bv) % 2) == 0) e = 1'b1;
    end
    return e;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_valid"},     sk_valid_p,  0);
    check({tag, "_key_ready"}, key_ready_p, 1);
    check({tag, "_last"},      last_p,      0);
    check({tag, "_valid_n"},   sk_valid_n,  0);
  endtask

  task automatic run_seq(input logic [63:0] k, input bit dec, input int rdy_pct,
                         input bit pulse_other, input int abort_at);
    int          pos;
    int          cycles;
    bit          aborted;
    bit          exp_err;
    logic [47:0] exp_sk;
    pos     = 0;
    cycles  = 0;
    aborted = 1'b0;
    build_model(k);
    exp_err = parity_err(k);

    @(negedge clk);
    check("key_ready_before", key_ready_p, 1);
    key       = k;
    decrypt   = dec;
    key_valid = 1'b1;
    sk_ready  = 1'b0;
    @(negedge clk);
    key_valid = 1'b0;
    key       = {$urandom, $urandom};
    decrypt   = ~dec;

    while (pos < 16 && cycles < 400) begin
      cycles++;
      exp_sk  = dec ? ref_ks[15 - pos] : ref_ks[pos];
      cap[pos] = sk_p;
      check("sk_valid",      sk_valid_p,  1);
      check("key_ready_run", key_ready_p, 0);
      check("round",         rnd_p,       pos);
      check("last",          last_p,      (pos == 15));
      check("subkey",        sk_p,        exp_sk);
      check("key_err",       err_p,       exp_err);
      check("subkey_np",     sk_n,        exp_sk);
      check("key_err_np",    err_n,       0);
      if (pos == abort_at) begin
        rst      = 1'b1;
        sk_ready = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        sk_ready = 1'b0;
        check_idle("abort");
        check("abort_subkey", sk_p,  0);
        check("abort_round",  rnd_p, 0);
        check("abort_err",    err_p, 0);
        aborted = 1'b1;
        break;
      end
      sk_ready = ($urandom_range(99) < rdy_pct);
      if (pulse_other) begin
        key       = {$urandom, $urandom};
        decrypt   = $urandom_range(1);
        key_valid = (pos == 15 && sk_ready) ? 1'b1 : 1'(($urandom_range(1)));
      end
      if (sk_ready) pos++;
      @(negedge clk);
    end

    if (!aborted) begin
      if (pos < 16) check("timeout_pos", pos, 16);
      check_idle("end");
      key_valid = 1'b0;
      sk_ready  = 1'b0;
    end
  endtask

  initial begin
    logic [63:0] rk;
    rst       = 1'b1;
    key_valid = 1'b0;
    key       = '0;
    decrypt   = 1'b0;
    sk_ready  = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    check("reset_subkey", sk_p,  0);
    check("reset_round",  rnd_p, 0);
    check("reset_err",    err_p, 0);
    rst = 1'b0;

    run_seq(64'h133457799BBCDFF1, 1'b0, 100, 1'b0, -1);
    check("kat_enc_k1",  cap[0],  48'h1B02EFFC7072);
    check("kat_enc_k2",  cap[1],  48'h79AED9DBC9E5);
    check("kat_enc_k16", cap[15], 48'hCB3D8B0E17F5);

    run_seq(64'h133457799BBCDFF1, 1'b1, 100, 1'b0, -1);
    check("kat_dec_first", cap[0],  48'hCB3D8B0E17F5);
    check("kat_dec_last",  cap[15], 48'h1B02EFFC7072);

    run_seq(64'h133457799BBCDFF1, 1'b0, 30, 1'b0, -1);

    run_seq(64'h133457799BBCDFF1, 1'b0, 100, 1'b0, 5);
    run_seq(64'h133457799BBCDFF1, 1'b0, 100, 1'b0, -1);
    check("restart_k1", cap[0], 48'h1B02EFFC7072);

    run_seq(64'h133457799BBCDFF1, 1'b0, 60, 1'b1, -1);
    run_seq(64'h0E329232EA6D0D73, 1'b1, 100, 1'b0, -1);

    run_seq(64'h0101010101010101, 1'b0, 100, 1'b0, -1);
    for (int i = 0; i < 16; i++) check("weak_zero", cap[i], 0);
    run_seq(64'h0101010101010101, 1'b1, 50, 1'b0, -1);

    for (int t = 0; t < 6; t++) begin
      rk = {$urandom, $urandom};
      if (t == 0) rk[7:0] = 8'h00;
      run_seq(rk, 1'($urandom_range(1)), 50, 1'b0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
